traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter MAX_DWELL, default 4, meaning the maximum consecutive cycles one light code may be held before a stuck error (legal range 1..14).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 light_in  input  2  light code from controller: 2'b00 green, 2'b01 yellow, 2'b10 red, 2'b11 illegal; sampled every posedge clk.
REQ-005 clear_err  input  1  synchronous clear of all sticky error flags.
REQ-006 green_o  output  1  lamp drive, registered one-hot decode of light_in.
REQ-007 yellow_o  output  1  lamp drive, registered one-hot decode of light_in.
REQ-008 red_o  output  1  lamp drive, registered one-hot decode of light_in.
REQ-009 seq_err  output  1  sticky flag: illegal code transition detected.
REQ-010 code_err  output  1  sticky flag: code 2'b11 received.
REQ-011 stuck_err  output  1  sticky flag: code held longer than MAX_DWELL cycles.
REQ-012 dwell_cnt  output  4  consecutive cycles the current code has been held.
REQ-013 cycle_cnt  output  8  count of completed red->green transitions.

Function
REQ-014 Two-state FSM: INIT (no reference code held) and TRACK (previous code held in prev_code register).
REQ-015 All outputs registered; each reflects the light_in sampled at the same posedge, i.e. 1-cycle latency.
REQ-016 Lamp decode: 00 -> green_o only; 01 -> yellow_o only; 10 -> red_o only; 11 -> all three lamps 0.
REQ-017 INIT with legal code: capture into prev_code, dwell_cnt=1, go TRACK, no sequence check.
REQ-018 TRACK legal transitions: hold same code, green->yellow, yellow->red, red->green.
REQ-019 TRACK illegal transitions (green->red, yellow->green, red->yellow): set seq_err, capture new code, dwell_cnt=1, stay TRACK.
REQ-020 Code 11 in any state: set code_err, lamps off, dwell_cnt=0, go INIT; no seq_err raised for this sample or for the next legal code.
REQ-021 Same code held: dwell_cnt increments, saturating at 15; code change: dwell_cnt=1.
REQ-022 stuck_err set on the sample where the code is held and dwell_cnt already equals MAX_DWELL.
REQ-023 Legal red->green transition in TRACK: cycle_cnt increments, wrapping 255->0; no increment from INIT or on illegal transitions.
REQ-024 Error flags remain 1 until clear_err or reset; clear_err=1 zeroes them the next posedge.
REQ-025 clear_err coincident with a new error event: the set wins; flag is 1 after that edge.
REQ-026 clear_err does not affect FSM state, dwell_cnt, cycle_cnt or lamps.

Reset
REQ-027 reset=1 asynchronously forces FSM=INIT, prev_code=red, all lamps 0, all error flags 0, dwell_cnt=0, cycle_cnt=0.
REQ-028 Reset asserted mid-operation discards all state; first sample after deassertion is handled as in REQ-017 with no seq_err.

Verification
REQ-029 Reset, then light_in red,green,yellow,red,green on successive edges -> lamps follow with 1-cycle latency, seq_err=0, cycle_cnt=2, dwell_cnt=1 each cycle.
REQ-030 TRACK on green, drive red -> seq_err=1 after that edge, red_o=1, dwell_cnt=1, cycle_cnt unchanged; seq_err stays 1 until clear_err pulse, then 0.
REQ-031 MAX_DWELL=4, hold yellow 5 cycles -> dwell_cnt 1,2,3,4,5, stuck_err=1 on 5th; hold 20 cycles -> dwell_cnt saturates at 15.
REQ-032 Drive 2'b11 then yellow after red -> code_err=1, all lamps 0, dwell_cnt=0, then yellow_o=1 with seq_err=0 (INIT re-entry).
REQ-033 Drive red->green 256 times legally -> cycle_cnt wraps to 0; clear_err asserted on same edge as green->red -> seq_err=1.
REQ-034 Assert reset asynchronously between edges mid-sequence with errors set -> all outputs 0 immediately, before next posedge.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic light code monitor: registered lamp decode, sticky sequence/code/stuck errors, dwell and cycle counters.
// Latency: every output reflects the light_in sampled at the same edge (1 cycle); no backpressure, one sample per clock.
module traffic_light_monitor #(
  parameter int MAX_DWELL = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light_in,
  input  logic       clear_err,
  output logic       green_o,
  output logic       yellow_o,
  output logic       red_o,
  output logic       seq_err,
  output logic       code_err,
  output logic       stuck_err,
  output logic [3:0] dwell_cnt,
  output logic [7:0] cycle_cnt
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [1:0] C_GREEN   = 2'b00;
  localparam logic [1:0] C_YELLOW  = 2'b01;
  localparam logic [1:0] C_RED     = 2'b10;
  localparam logic [1:0] C_ILLEGAL = 2'b11;

  localparam logic [3:0] DWELL_LIMIT = 4'(MAX_DWELL);
  localparam logic [3:0] DWELL_SAT   = 4'hF;

  state_t     state_q, state_d;
  logic [1:0] prev_code_q, prev_code_d;
  logic [2:0] lamps_q, lamps_d;
  logic       seq_err_q, seq_err_d;
  logic       code_err_q, code_err_d;
  logic       stuck_err_q, stuck_err_d;
  logic [3:0] dwell_cnt_q, dwell_cnt_d;
  logic [7:0] cycle_cnt_q, cycle_cnt_d;

  logic is_hold;
  logic is_legal_step;
  logic ev_seq;
  logic ev_code;
  logic ev_stuck;

  always_comb begin
    state_d     = state_q;
    prev_code_d = prev_code_q;
    dwell_cnt_d = dwell_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    ev_seq      = 1'b0;
    ev_code     = 1'b0;
    ev_stuck    = 1'b0;

    is_hold       = (light_in == prev_code_q);
    is_legal_step = ((prev_code_q == C_GREEN)  && (light_in == C_YELLOW)) ||
                    ((prev_code_q == C_YELLOW) && (light_in == C_RED))    ||
                    ((prev_code_q == C_RED)    && (light_in == C_GREEN));

    // lamps_q packs {green, yellow, red}
    case (light_in)
      C_GREEN:  lamps_d = 3'b100;
      C_YELLOW: lamps_d = 3'b010;
      C_RED:    lamps_d = 3'b001;
      default:  lamps_d = 3'b000;
    endcase

    if (light_in == C_ILLEGAL) begin
      // Dropping back to INIT means the next legal code is accepted without a sequence check.
      ev_code     = 1'b1;
      state_d     = ST_INIT;
      dwell_cnt_d = 4'd0;
    end else if (state_q == ST_INIT) begin
      prev_code_d = light_in;
      dwell_cnt_d = 4'd1;
      state_d     = ST_TRACK;
    end else if (is_hold) begin
      ev_stuck    = (dwell_cnt_q == DWELL_LIMIT);
      dwell_cnt_d = (dwell_cnt_q == DWELL_SAT) ? dwell_cnt_q : dwell_cnt_q + 4'd1;
    end else begin
      prev_code_d = light_in;
      dwell_cnt_d = 4'd1;
      if (is_legal_step) begin
        if (prev_code_q == C_RED) begin
          cycle_cnt_d = cycle_cnt_q + 8'd1;
        end
      end else begin
        ev_seq = 1'b1;
      end
    end

    // A new error event outranks a coincident clear.
    seq_err_d   = (seq_err_q   & ~clear_err) | ev_seq;
    code_err_d  = (code_err_q  & ~clear_err) | ev_code;
    stuck_err_d = (stuck_err_q & ~clear_err) | ev_stuck;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      prev_code_q <= C_RED;
      lamps_q     <= 3'b000;
      seq_err_q   <= 1'b0;
      code_err_q  <= 1'b0;
      stuck_err_q <= 1'b0;
      dwell_cnt_q <= 4'd0;
      cycle_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_code_q <= prev_code_d;
      lamps_q     <= lamps_d;
      seq_err_q   <= seq_err_d;
      code_err_q  <= code_err_d;
      stuck_err_q <= stuck_err_d;
      dwell_cnt_q <= dwell_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign green_o   = lamps_q[2];
  assign yellow_o  = lamps_q[1];
  assign red_o     = lamps_q[0];
  assign seq_err   = seq_err_q;
  assign code_err  = code_err_q;
  assign stuck_err = stuck_err_q;
  assign dwell_cnt = dwell_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random codes checked against a rule-level model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_traffic_light_monitor;

  localparam int MAX_DWELL = 4;

  logic       clk;
  logic       reset;
  logic [1:0] light_in;
  logic       clear_err;
  logic       green_o, yellow_o, red_o;
  logic       seq_err, code_err, stuck_err;
  logic [3:0] dwell_cnt;
  logic [7:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: codes 0=green,1=yellow,2=red advance as (c+1)%3.
  bit m_have_ref;
  int m_ref;
  int m_dwell;
  int m_cycles;
  bit m_seq, m_code, m_stuck;
  int m_lamps;

  traffic_light_monitor #(.MAX_DWELL(MAX_DWELL)) dut (
    .clk       (clk),
    .reset     (reset),
    .light_in  (light_in),
    .clear_err (clear_err),
    .green_o   (green_o),
    .yellow_o  (yellow_o),
    .red_o     (red_o),
    .seq_err   (seq_err),
    .code_err  (code_err),
    .stuck_err (stuck_err),
    .dwell_cnt (dwell_cnt),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_have_ref = 0;
    m_ref      = 2;
    m_dwell    = 0;
    m_cycles   = 0;
    m_seq      = 0;
    m_code     = 0;
    m_stuck    = 0;
    m_lamps    = 0;
  endtask

  task automatic model_step(input int code, input bit clr);
    bit s_seq, s_code, s_stuck;
    s_seq = 0; s_code = 0; s_stuck = 0;
    m_lamps = (code == 3) ? 0 : (4 >> code);
    if (code == 3) begin
      s_code     = 1;
      m_have_ref = 0;
      m_dwell    = 0;
    end else if (!m_have_ref) begin
      m_have_ref = 1;
      m_ref      = code;
      m_dwell    = 1;
    end else if (code == m_ref) begin
      if (m_dwell == MAX_DWELL) s_stuck = 1;
      m_dwell = (m_dwell + 1 > 15) ? 15 : m_dwell + 1;
    end else begin
      if (code == (m_ref + 1) % 3) begin
        if (m_ref == 2) m_cycles = (m_cycles + 1) % 256;
      end else begin
        s_seq = 1;
      end
      m_ref   = code;
      m_dwell = 1;
    end
    m_seq   = (m_seq   && !clr) || s_seq;
    m_code  = (m_code  && !clr) || s_code;
    m_stuck = (m_stuck && !clr) || s_stuck;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lamps"}, {5'd0, green_o, yellow_o, red_o}, 8'(m_lamps));
    chk({tag, ".seq_err"},   {7'd0, seq_err},   {7'd0, m_seq});
    chk({tag, ".code_err"},  {7'd0, code_err},  {7'd0, m_code});
    chk({tag, ".stuck_err"}, {7'd0, stuck_err}, {7'd0, m_stuck});
    chk({tag, ".dwell_cnt"}, {4'd0, dwell_cnt}, 8'(m_dwell));
    chk({tag, ".cycle_cnt"}, cycle_cnt,         8'(m_cycles));
  endtask

  task automatic step(input string tag, input logic [1:0] code, input logic clr);
    light_in  = code;
    clear_err = clr;
    @(posedge clk);
    #1;
    model_step(int'(code), clr);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] code;
    int         r;

    reset     = 1'b1;
    light_in  = 2'b00;
    clear_err = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;

    // Legal loop red,green,yellow,red,green
    step("seq029_r", 2'b10, 1'b0);
    step("seq029_g", 2'b00, 1'b0);
    step("seq029_y", 2'b01, 1'b0);
    step("seq029_r2", 2'b10, 1'b0);
    step("seq029_g2", 2'b00, 1'b0);
    chk("seq029_cycles", cycle_cnt, 8'd2);
    chk("seq029_seq", {7'd0, seq_err}, 8'd0);

    // green -> red is illegal; flag sticks until cleared
    step("seq030_bad", 2'b10, 1'b0);
    chk("seq030_flag", {7'd0, seq_err}, 8'd1);
    step("seq030_hold", 2'b10, 1'b0);
    step("seq030_clr", 2'b10, 1'b1);
    chk("seq030_cleared", {7'd0, seq_err}, 8'd0);

    // Dwell and stuck on a held yellow
    async_reset("rst031");
    for (int i = 0; i < 20; i++) begin
      step($sformatf("dwell031_%0d", i), 2'b01, 1'b0);
      if (i == 4) chk("dwell031_stuck", {7'd0, stuck_err}, 8'd1);
    end
    chk("dwell031_sat", {4'd0, dwell_cnt}, 8'd15);

    // Illegal code, then yellow re-enters without a sequence error
    step("code032_r", 2'b10, 1'b1);
    step("code032_x", 2'b11, 1'b0);
    chk("code032_dwell", {4'd0, dwell_cnt}, 8'd0);
    step("code032_y", 2'b01, 1'b0);
    chk("code032_seq", {7'd0, seq_err}, 8'd0);

    // 256 legal red->green transitions wrap cycle_cnt
    async_reset("rst033");
    step("wrap033_r", 2'b10, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step("wrap033_g", 2'b00, 1'b0);
      if (i < 255) begin
        step("wrap033_y", 2'b01, 1'b0);
        step("wrap033_r", 2'b10, 1'b0);
      end
    end
    chk("wrap033_zero", cycle_cnt, 8'd0);
    step("wrap033_setwins", 2'b10, 1'b1);
    chk("wrap033_seq", {7'd0, seq_err}, 8'd1);

    // Async reset with errors set
    step("rst034_x", 2'b11, 1'b0);
    async_reset("rst034");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      code = 2'((m_ref + 1) % 3);
      else if (r < 75) code = 2'(m_ref);
      else if (r < 93) code = 2'($urandom_range(0, 2));
      else             code = 2'b11;
      step("rand", code, ($urandom_range(0, 7) == 0));
      if ((i % 100) == 99) async_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
